// File: rtl/priority_encoder_nx_reg.sv
// -----------------------------------------------------------------------------
// priority_encoder_nx_reg
//
// Registered N-to-W priority encoder with a one-deep valid/ready output stage.
// A captured request vector is reduced to the index of its winning bit.
// MSB_PRIORITY=1 selects the highest set bit and 0 selects the lowest.
// The result is flagged as empty (any=0) or multi-hot (multi=1).
// Every accepted multi-hot vector bumps a saturating error counter.
//
// Ports
//   clk        : clock, rising edge
//   rst        : synchronous active-high reset
//   in_valid   : d carries a request vector this cycle
//   in_ready   : stage can take d this cycle (!out_valid || out_ready)
//   d[N-1:0]   : request vector, d[0] is index 0
//   out_valid  : a / any / multi hold a result
//   out_ready  : consumer takes the result this cycle
//   a[W-1:0]   : index of the winning request bit
//   any        : captured vector had at least one bit set
//   multi      : captured vector had two or more bits set
//   err_count  : saturating count of accepted multi-hot vectors
// -----------------------------------------------------------------------------
module priority_encoder_nx_reg #(
   parameter int  N            = 8,
   parameter bit  MSB_PRIORITY = 1'b1,
   parameter int  CNT_W        = 8,
   localparam int W            = $clog2(N)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [N-1:0]     d,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [W-1:0]     a,
   output logic             any,
   output logic             multi,
   output logic [CNT_W-1:0] err_count
);

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_t;

   state_t           state_reg;
   logic [W-1:0]     a_reg;
   logic             any_reg;
   logic             multi_reg;
   logic [CNT_W-1:0] err_count_reg;

   logic [W-1:0]     win_idx;
   logic             any_hot;
   logic             multi_hot;
   logic             accept;

   // The loop only ever assigns indices 0..N-1, so a non-power-of-two N
   // can never produce an out-of-range index.
   generate
      if (MSB_PRIORITY) begin : g_msb
         // Ascending scan: the last (highest) set bit overwrites earlier ones.
         always_comb begin
            win_idx = '0;
            for (int i = 0; i < N; i++) begin
               if (d[i]) win_idx = W'(i);
            end
         end
      end else begin : g_lsb
         // Descending scan: the last (lowest) set bit overwrites earlier ones.
         always_comb begin
            win_idx = '0;
            for (int i = N - 1; i >= 0; i--) begin
               if (d[i]) win_idx = W'(i);
            end
         end
      end
   endgenerate

   assign any_hot   = |d;
   // Clearing the lowest set bit leaves something only if two or more were set.
   assign multi_hot = |(d & (d - N'(1)));

   assign out_valid = (state_reg == FULL);
   assign in_ready  = !out_valid || out_ready;
   assign accept    = in_valid && in_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= EMPTY;
         a_reg         <= '0;
         any_reg       <= 1'b0;
         multi_reg     <= 1'b0;
         err_count_reg <= '0;
      end else begin
         if (accept) begin
            // Covers both a fill from EMPTY and a same-edge pop+push in FULL.
            state_reg <= FULL;
            a_reg     <= win_idx;
            any_reg   <= any_hot;
            multi_reg <= multi_hot;
            if (multi_hot && (err_count_reg != {CNT_W{1'b1}})) begin
               err_count_reg <= err_count_reg + CNT_W'(1);
            end
         end else if ((state_reg == FULL) && out_ready) begin
            state_reg <= EMPTY;
         end
      end
   end

   assign a         = a_reg;
   assign any       = any_reg;
   assign multi     = multi_reg;
   assign err_count = err_count_reg;

endmodule

// File: tb/tb_priority_encoder_nx_reg.sv
// -----------------------------------------------------------------------------
// tb_priority_encoder_nx_reg
//
// Bench for priority_encoder_nx_reg with three instances:
//   m_* : N=8, MSB priority, CNT_W=8 (main table, back-pressure, reset)
//   f_* : N=5, LSB priority (non-power-of-two width)
//   s_* : N=8, MSB priority, CNT_W=2 (counter saturation)
// -----------------------------------------------------------------------------
module tb_priority_encoder_nx_reg;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   // main instance
   logic       m_in_valid, m_in_ready, m_out_valid, m_out_ready, m_any, m_multi;
   logic [7:0] m_d, m_err;
   logic [2:0] m_a;

   // N=5 LSB instance
   logic       f_in_valid, f_in_ready, f_out_valid, f_out_ready, f_any, f_multi;
   logic [4:0] f_d;
   logic [7:0] f_err;
   logic [2:0] f_a;

   // CNT_W=2 instance
   logic       s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_any, s_multi;
   logic [7:0] s_d;
   logic [1:0] s_err;
   logic [2:0] s_a;

   priority_encoder_nx_reg #(.N(8), .MSB_PRIORITY(1'b1), .CNT_W(8)) dut_m (
      .clk(clk), .rst(rst), .in_valid(m_in_valid), .in_ready(m_in_ready), .d(m_d),
      .out_valid(m_out_valid), .out_ready(m_out_ready), .a(m_a), .any(m_any),
      .multi(m_multi), .err_count(m_err));

   priority_encoder_nx_reg #(.N(5), .MSB_PRIORITY(1'b0), .CNT_W(8)) dut_f (
      .clk(clk), .rst(rst), .in_valid(f_in_valid), .in_ready(f_in_ready), .d(f_d),
      .out_valid(f_out_valid), .out_ready(f_out_ready), .a(f_a), .any(f_any),
      .multi(f_multi), .err_count(f_err));

   priority_encoder_nx_reg #(.N(8), .MSB_PRIORITY(1'b1), .CNT_W(2)) dut_s (
      .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready), .d(s_d),
      .out_valid(s_out_valid), .out_ready(s_out_ready), .a(s_a), .any(s_any),
      .multi(s_multi), .err_count(s_err));

   int n_vec = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic [7:0] d;
      logic [2:0] a;
      logic       any;
      logic       multi;
      logic [7:0] err;
   } vec_t;

   vec_t tbl[14];

   initial begin
      // single-hot sweep, then zero, then multi-hot vectors
      for (int i = 0; i < 8; i++) tbl[i] = '{8'h01 << i, 3'(i), 1'b1, 1'b0, 8'd0};
      tbl[8]  = '{8'h00, 3'd0, 1'b0, 1'b0, 8'd0};
      tbl[9]  = '{8'hA5, 3'd7, 1'b1, 1'b1, 8'd1};
      tbl[10] = '{8'h81, 3'd7, 1'b1, 1'b1, 8'd2};
      tbl[11] = '{8'h06, 3'd2, 1'b1, 1'b1, 8'd3};
      tbl[12] = '{8'h40, 3'd6, 1'b1, 1'b0, 8'd3};
      tbl[13] = '{8'hFF, 3'd7, 1'b1, 1'b1, 8'd4};

      rst = 1'b1;
      m_in_valid = 0; m_out_ready = 1; m_d = '0;
      f_in_valid = 0; f_out_ready = 1; f_d = '0;
      s_in_valid = 0; s_out_ready = 1; s_d = '0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b0;

      // reset state
      chk("rst_out_valid", m_out_valid, 0);
      chk("rst_a", m_a, 0);
      chk("rst_any", m_any, 0);
      chk("rst_multi", m_multi, 0);
      chk("rst_err", m_err, 0);
      chk("rst_in_ready", m_in_ready, 1);

      // streaming table, out_ready held high
      for (int i = 0; i < 14; i++) begin
         m_in_valid = 1; m_d = tbl[i].d;
         @(posedge clk); #1;
         $display("vec %0d: d=%h a=%0d any=%b multi=%b err=%0d", i, m_d, m_a, m_any, m_multi, m_err);
         chk("tbl_out_valid", m_out_valid, 1);
         chk("tbl_a", m_a, tbl[i].a);
         chk("tbl_any", m_any, tbl[i].any);
         chk("tbl_multi", m_multi, tbl[i].multi);
         chk("tbl_err", m_err, tbl[i].err);
      end

      // drain: FULL -> EMPTY on out_ready && !in_valid
      m_in_valid = 0;
      @(posedge clk); #1;
      chk("drain_out_valid", m_out_valid, 0);
      chk("drain_in_ready", m_in_ready, 1);

      // back-pressure
      m_in_valid = 1; m_d = 8'h10;
      @(posedge clk); #1;
      chk("bp_cap_a", m_a, 4);
      m_out_ready = 0; m_d = 8'h02;
      #1;
      chk("bp_in_ready_comb", m_in_ready, 0);
      for (int c = 0; c < 4; c++) begin
         @(posedge clk); #1;
         $display("bp cycle %0d: in_ready=%b a=%0d out_valid=%b", c, m_in_ready, m_a, m_out_valid);
         chk("bp_hold_a", m_a, 4);
         chk("bp_hold_valid", m_out_valid, 1);
         chk("bp_in_ready", m_in_ready, 0);
      end
      m_out_ready = 1;
      #1;
      chk("bp_release_in_ready", m_in_ready, 1);
      @(posedge clk); #1;
      chk("bp_new_a", m_a, 1);
      chk("bp_new_valid", m_out_valid, 1);
      chk("bp_err_same", m_err, 4);

      // N=5 LSB priority
      f_in_valid = 1; f_d = 5'b10100;
      @(posedge clk); #1;
      $display("n5: d=%b a=%0d multi=%b", f_d, f_a, f_multi);
      chk("n5_a0", f_a, 2);
      chk("n5_multi0", f_multi, 1);
      f_d = 5'b10000;
      @(posedge clk); #1;
      $display("n5: d=%b a=%0d multi=%b", f_d, f_a, f_multi);
      chk("n5_a1", f_a, 4);
      chk("n5_multi1", f_multi, 0);
      chk("n5_any1", f_any, 1);
      f_d = 5'b11111;
      @(posedge clk); #1;
      $display("n5: d=%b a=%0d multi=%b", f_d, f_a, f_multi);
      chk("n5_a2", f_a, 0);
      chk("n5_err", f_err, 2);
      f_in_valid = 0;

      // counter saturation, CNT_W=2
      for (int i = 0; i < 5; i++) begin
         s_in_valid = 1; s_d = 8'h03 << i;
         @(posedge clk); #1;
         $display("sat %0d: d=%h err=%0d", i, s_d, s_err);
         chk("sat_err", s_err, (i < 3) ? i + 1 : 3);
      end
      s_in_valid = 0;

      // reset mid-operation with err_count=2
      rst = 1; @(posedge clk); #1; rst = 0;
      m_out_ready = 1; m_in_valid = 1;
      m_d = 8'h03; @(posedge clk); #1;
      m_d = 8'h0C; @(posedge clk); #1;
      chk("mid_err_pre", m_err, 2);
      chk("mid_valid_pre", m_out_valid, 1);
      m_out_ready = 0; m_d = 8'hFF; rst = 1;
      @(posedge clk); #1;
      $display("mid rst: valid=%b a=%0d any=%b multi=%b err=%0d in_ready=%b",
               m_out_valid, m_a, m_any, m_multi, m_err, m_in_ready);
      chk("mid_valid", m_out_valid, 0);
      chk("mid_a", m_a, 0);
      chk("mid_any", m_any, 0);
      chk("mid_multi", m_multi, 0);
      chk("mid_err", m_err, 0);
      chk("mid_in_ready", m_in_ready, 1);
      rst = 0; m_in_valid = 0;
      @(posedge clk); #1;
      chk("post_valid", m_out_valid, 0);
      chk("post_err", m_err, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/priority_encoder_nx_reg.md
# priority_encoder_nx_reg

Parametrised, registered priority encoder: compresses an N-bit request vector into a W-bit binary index with a one-deep valid/ready output stage. It generalises the fixed 8-to-3 combinational encoders in the combinational-circuits library. It adds these behaviours:
- selectable priority direction;
- zero and multi-hot detection;
- back-pressure;
- a saturating multi-hot error counter.

It sits between request-generating logic and any consumer that needs a registered index.

## Interface
- N, default 8: input vector width. Legal range is 2..256.
- W, localparam, $clog2(N): index width. It is not overridable.
- MSB_PRIORITY, default 1: 1 makes the highest set bit win; 0 makes the lowest set bit win.
- CNT_W, default 8: width of the multi-hot error counter.

- clk, input, 1: single clock, rising edge.
- rst, input, 1: synchronous, active-high reset.
- in_valid, input, 1: d is valid this cycle.
- in_ready, output, 1: block can accept d this cycle.
- d, input, N: request vector. d[0] is index 0.
- out_valid, output, 1: a, any and multi hold a result.
- out_ready, input, 1: consumer accepts the result this cycle.
- a, output, W: encoded index of the winning bit.
- any, output, 1: at least one bit of the captured d was set.
- multi, output, 1: two or more bits of the captured d were set.
- err_count, output, CNT_W: number of accepted multi-hot vectors, saturating.

## Operation
- The output stage has two states.
  - EMPTY: out_valid=0.
  - FULL: out_valid=1.
- in_ready = !out_valid || out_ready. It is combinational and has no dependency on in_valid.
- Accept occurs when in_valid && in_ready.
- State transitions:
  - EMPTY to FULL on accept.
  - FULL to EMPTY on out_ready && !in_valid.
  - FULL stays FULL on out_ready && in_valid; the new result replaces the old one in the same edge.
  - FULL stays FULL holding its registers on !out_ready.
- Encoding on accept:
  - With MSB_PRIORITY=1, a is the index of the highest set bit of d.
  - With MSB_PRIORITY=0, a is the index of the lowest set bit of d.
  - d==0 gives a=0, any=0 and multi=0.
  - Exactly one bit set gives any=1, multi=0, and a equal to that bit's index.
  - Two or more bits set gives any=1, multi=1, and a equal to the priority winner.
- When N is not a power of two, a never exceeds N-1.
- err_count increments by 1 on each accept with multi-hot d. It saturates at 2^CNT_W-1 and never wraps.
- err_count is cleared only by rst.
- While FULL and !out_ready, a, any and multi hold stable. d is ignored and is not sampled.
- rst asserted on any edge forces:
  - out_valid=0, a=0, any=0, multi=0 and err_count=0;
  - state EMPTY.
- rst overrides a simultaneous accept. The accepted vector is discarded and err_count does not increment.
- During rst, in_ready follows its equation and is therefore 1, because out_valid=0.

## Timing
- Latency: d accepted at edge k appears on a, any and multi with out_valid=1 after edge k, one cycle.
- Throughput: one result per cycle while out_ready=1.
- No combinational path exists from d to any output.
- The only combinational input-to-output path is out_ready to in_ready.
- All outputs except in_ready are registered.
- Reset values:
  - out_valid=0, a=0, any=0, multi=0, err_count=0;
  - in_ready=1 after reset.
- Simultaneous pop and push while FULL causes no bubble. out_valid stays 1 and the data changes at that edge.
- err_count updates on the same edge as the capture of the offending vector.

## Test plan
- Reset, then single-hot sweep.
  - Stimulus: N=8, MSB_PRIORITY=1, out_ready=1; drive d=8'h01, 02, 04 … 80 on consecutive cycles.
  - Required: a=0..7 one cycle later each, any=1, multi=0, out_valid continuously 1, err_count=0.
- Zero and multi-hot with MSB priority.
  - Stimulus: MSB_PRIORITY=1; d=8'h00, then 8'hA5.
  - Required: first result a=0, any=0, multi=0. Second result a=7, multi=1. err_count=1.
- LSB priority and non-power-of-two width.
  - Stimulus: N=5, MSB_PRIORITY=0, W=3; d=5'b10100, then 5'b10000.
  - Required: a=2 with multi=1, then a=4 with multi=0.
- Back-pressure.
  - Stimulus: capture d=8'h10, hold out_ready=0 for 4 cycles while driving in_valid=1 with d=8'h02.
  - Required: in_ready=0 and a=4 held all 4 cycles. On out_ready=1, that same edge loads a=1 and out_valid stays 1.
- Counter saturation.
  - Stimulus: CNT_W=2; accept 5 multi-hot vectors.
  - Required: err_count goes 1, 2, 3, 3, 3.
- Reset mid-operation.
  - Stimulus: while FULL with err_count=2, assert rst together with in_valid=1 and d=8'hFF.
  - Required: after the edge, out_valid=0, a=0, any=0, multi=0, err_count=0, and in_ready=1.
